tt_um_clkdiv_prog: RTL and testbench
====================================

// Module: tt_um_clkdiv_prog
// PURPOSE
//  Multi-channel programmable clock divider; successor to the fixed ripple /2../16 chain.
//  Fully synchronous: every channel runs on clk with its own counter. No derived clocks.
//  Each channel gives a registered divided waveform plus a one-cycle tick strobe.
//  Divisors are reprogrammable at run time and update glitch-free at period boundaries.
// PARAMETERS
//  CHANNELS   4  number of divider channels (>=2)
//  WIDTH      8  divisor/counter width; legal divisors 2..2^WIDTH-1
//  RESET_DIV  2  divisor loaded into every channel at reset (>=2, < 2^WIDTH)
//  SEL_W      $clog2(CHANNELS)  localparam, width of div_sel
// PORTS
//  clk       in   1         system clock
//  reset     in   1         asynchronous, active-high reset
//  en        in   1         global count enable
//  div_load  in   1         write strobe for div_val into channel div_sel
//  div_sel   in   SEL_W     target channel; values >= CHANNELS ignored
//  div_val   in   WIDTH     new divisor D
//  clk_out   out  CHANNELS  registered divided waveforms
//  tick      out  CHANNELS  one-cycle strobe per channel period
//  pending   out  CHANNELS  shadow divisor waiting for period boundary
//  sync      in   1         only with CLKDIV_SYNC_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async): cnt=0, active D=RESET_DIV, shadow=RESET_DIV, clk_out=0, tick=0, pending=0.
//  - Per channel, enabled edge (en=1, D>=2): cnt <= (cnt==D-1) ? 0 : cnt+1.
//    tick   <= (cnt==D-1)     -> high in the cycle cnt has just wrapped to 0.
//    clk_out<= (cnt_next < D>>1) -> high D>>1 cycles, low D-(D>>1) per period.
//    Period = exactly D clk cycles; first tick D cycles after reset release.
//  - en=0: cnt and clk_out hold, tick forced 0; loads still accepted.
//  - Load: div_load=1 -> shadow[div_sel]<=div_val, pending[div_sel]<=1 next edge.
//    Applied at wrap (enabled edge with cnt==D-1): active<=shadow, pending<=0.
//    Load while pending already set: shadow overwritten, last write wins.
//    Load on same edge as that channel's wrap: active<=div_val directly, pending stays 0.
//  - D<2 (0 or 1) = halted: cnt=0, clk_out=0, tick=0. A load to a halted channel
//    applies on the next edge (en-independent), counting restarts from cnt=0.
//  - Channels are independent; simultaneous loads impossible (one port), wraps may coincide.
//  - Reset mid-operation: immediate return to reset values; shadow loads discarded.
//  - All outputs are flops; no combinational path input->output.
// CONFIGURATION
//  CLKDIV_SYNC_EN defined: adds input port sync. sync=1 on an edge (priority over en
//   and wrap): every channel cnt<=0, clk_out<=0, tick<=0, pending shadows applied,
//   pending<=0. Phase-aligns all channels; a sync/div_load collision applies div_val.
//  CLKDIV_SYNC_EN undefined: sync port absent; channels align only via reset.
// TESTING
//  1 reset, en=1, no loads -> all clk_out period 2 (0,1,0,1..), tick every 2nd cycle, pending=0.
//  2 load ch1 D=5 mid-period -> pending[1]=1 until ch1 wraps, then clk_out[1] 2 high/3 low,
//    tick[1] every 5 cycles; other channels unchanged.
//  3 load ch2 D=0 -> clk_out[2]=0, tick[2]=0 indefinitely; load D=4 -> period 4 restarts next edge.
//  4 ch0 D=6, drop en for 3 cycles at cnt=2 -> outputs frozen, tick absent, next tick 3 cycles late.
//  5 assert reset while pending[3]=1, D=7 -> outputs 0 at once, post-release period 2, pending 0.
//  6 (CLKDIV_SYNC_EN) ch0 D=3, ch1 D=6, pulse sync -> tick[0] at +3,+6, tick[1] at +6; both coincide at +6.

Source files
------------

// File: rtl/tt_um_clkdiv_prog.sv
// Multi-channel programmable clock divider: one counter per channel, registered waveform and tick,
// shadow divisor taken over at the period wrap. Define CLKDIV_SYNC_EN to add the sync phase-align input.
module tt_um_clkdiv_prog #(
    parameter  int CHANNELS  = 4,
    parameter  int WIDTH     = 8,
    parameter  int RESET_DIV = 2,
    localparam int SEL_W     = $clog2(CHANNELS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                div_load,
    input  logic [SEL_W-1:0]    div_sel,
    input  logic [WIDTH-1:0]    div_val,
`ifdef CLKDIV_SYNC_EN
    input  logic                sync,
`endif
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] pending
);

    logic [CHANNELS-1:0][WIDTH-1:0] cnt_q, cnt_d;
    logic [CHANNELS-1:0][WIDTH-1:0] div_q, div_d;
    logic [CHANNELS-1:0][WIDTH-1:0] shd_q, shd_d;
    logic [CHANNELS-1:0]            clk_q, clk_d;
    logic [CHANNELS-1:0]            tick_q, tick_d;
    logic [CHANNELS-1:0]            pend_q, pend_d;
    logic [CHANNELS-1:0]            hit;
    logic                           sync_w;

`ifdef CLKDIV_SYNC_EN
    assign sync_w = sync;
`else
    assign sync_w = 1'b0;
`endif

    function automatic logic runs(input logic [WIDTH-1:0] d);
        return d >= WIDTH'(2);
    endfunction

    // High for the first D>>1 counts of a period; a halted divisor keeps the waveform low.
    function automatic logic high_phase(input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d);
        return runs(d) && (c < (d >> 1));
    endfunction

    always_comb begin
        hit = '0;
        if (div_load && (int'(div_sel) < CHANNELS)) hit[div_sel] = 1'b1;
    end

    always_comb begin
        cnt_d  = cnt_q;
        div_d  = div_q;
        shd_d  = shd_q;
        pend_d = pend_q;
        clk_d  = clk_q;
        tick_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sync_w) begin
                // A load colliding with sync wins over any older shadow value.
                if (hit[i])          div_d[i] = div_val;
                else if (pend_q[i])  div_d[i] = shd_q[i];
                pend_d[i] = 1'b0;
                cnt_d[i]  = '0;
                clk_d[i]  = 1'b0;
            end else if (!runs(div_q[i])) begin
                cnt_d[i] = '0;
                clk_d[i] = 1'b0;
                if (hit[i]) begin
                    div_d[i] = div_val;
                    clk_d[i] = high_phase('0, div_val);
                end
            end else if (en && (cnt_q[i] == div_q[i] - WIDTH'(1))) begin
                cnt_d[i]  = '0;
                tick_d[i] = 1'b1;
                if (hit[i])          div_d[i] = div_val;
                else if (pend_q[i])  div_d[i] = shd_q[i];
                pend_d[i] = 1'b0;
                clk_d[i]  = high_phase('0, div_d[i]);
            end else begin
                if (en) begin
                    cnt_d[i] = cnt_q[i] + WIDTH'(1);
                    clk_d[i] = high_phase(cnt_d[i], div_q[i]);
                end
                if (hit[i]) begin
                    shd_d[i]  = div_val;
                    pend_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            div_q  <= {CHANNELS{WIDTH'(RESET_DIV)}};
            shd_q  <= {CHANNELS{WIDTH'(RESET_DIV)}};
            pend_q <= '0;
            clk_q  <= '0;
            tick_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            shd_q  <= shd_d;
            pend_q <= pend_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

    assign clk_out = clk_q;
    assign tick    = tick_q;
    assign pending = pend_q;

endmodule

// File: tb/tb_tt_um_clkdiv_prog.sv
// Bench for tt_um_clkdiv_prog: table vectors, hand corner sequences, randomized run against a
// period-position reference model. Sync checks compile only with CLKDIV_SYNC_EN.
`timescale 1ns/1ps
module tb_tt_um_clkdiv_prog;
    localparam int CH = 4;

    logic          clk = 1'b0;
    logic          reset, en, div_load;
    logic [1:0]    div_sel;
    logic [7:0]    div_val;
`ifdef CLKDIV_SYNC_EN
    logic          sync;
`endif
    logic [CH-1:0] clk_out, tick, pending;

    int total = 0;
    int bad   = 0;

    // Reference: active divisor, shadow, position inside the current period.
    int mD[CH], mShd[CH], mPos[CH];
    bit mPend[CH], mFresh[CH], mTick[CH];

    typedef struct {
        bit       en;
        bit       ld;
        int       sel;
        int       val;
        logic [3:0] ec;
        logic [3:0] et;
        logic [3:0] ep;
    } vec_t;
    vec_t tbl[11];

    tt_um_clkdiv_prog dut (
        .clk(clk), .reset(reset), .en(en), .div_load(div_load),
        .div_sel(div_sel), .div_val(div_val),
`ifdef CLKDIV_SYNC_EN
        .sync(sync),
`endif
        .clk_out(clk_out), .tick(tick), .pending(pending)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int i = 0; i < CH; i++) begin
            mD[i] = 2; mShd[i] = 2; mPos[i] = 0;
            mPend[i] = 0; mFresh[i] = 1; mTick[i] = 0;
        end
    endfunction

    function automatic void model_step();
        bit s = 0;
`ifdef CLKDIV_SYNC_EN
        s = sync;
`endif
        for (int i = 0; i < CH; i++) begin
            bit h = div_load && (int'(div_sel) == i);
            mTick[i] = 0;
            if (s) begin
                if (h) mD[i] = div_val; else if (mPend[i]) mD[i] = mShd[i];
                mPend[i] = 0; mPos[i] = 0; mFresh[i] = 1;
            end else if (mD[i] < 2) begin
                mPos[i] = 0;
                if (h) begin mD[i] = div_val; mFresh[i] = 0; end
            end else if (en) begin
                mFresh[i] = 0;
                mPos[i] = mPos[i] + 1;
                if (mPos[i] == mD[i]) begin
                    mPos[i] = 0; mTick[i] = 1;
                    if (h) mD[i] = div_val; else if (mPend[i]) mD[i] = mShd[i];
                    mPend[i] = 0;
                end else if (h) begin
                    mShd[i] = div_val; mPend[i] = 1;
                end
            end else if (h) begin
                mShd[i] = div_val; mPend[i] = 1;
            end
        end
    endfunction

    function automatic logic [3:0] exp_clk();
        logic [3:0] v;
        for (int i = 0; i < CH; i++)
            v[i] = !mFresh[i] && (mD[i] >= 2) && (mPos[i] < mD[i] / 2);
        return v;
    endfunction

    function automatic logic [3:0] exp_tick();
        logic [3:0] v;
        for (int i = 0; i < CH; i++) v[i] = mTick[i];
        return v;
    endfunction

    function automatic logic [3:0] exp_pend();
        logic [3:0] v;
        for (int i = 0; i < CH; i++) v[i] = mPend[i];
        return v;
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", name, act, want, $time);
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check({tag, " clk_out"}, clk_out, exp_clk());
        check({tag, " tick"},    tick,    exp_tick());
        check({tag, " pending"}, pending, exp_pend());
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b1;
        #1 model_reset();
        check("rst clk_out", clk_out, 4'b0000);
        check("rst tick",    tick,    4'b0000);
        check("rst pending", pending, 4'b0000);
        #2 reset = 1'b0;
    endtask

    task automatic load(input int ch, input int val, input string tag);
        div_load = 1'b1; div_sel = 2'(ch); div_val = 8'(val);
        step(tag);
        div_load = 1'b0;
    endtask

    initial begin
        int  n;
        bit  found;
        reset = 1'b1; en = 1'b1; div_load = 1'b0; div_sel = '0; div_val = '0;
`ifdef CLKDIV_SYNC_EN
        sync = 1'b0;
`endif
        model_reset();
        #3;
        check("init clk_out", clk_out, 4'b0000);
        check("init tick",    tick,    4'b0000);
        check("init pending", pending, 4'b0000);
        #9 reset = 1'b0;

        // Period 2 everywhere, then a mid-period load of D=5 into channel 1.
        tbl[0]  = '{1, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000};
        tbl[1]  = '{1, 0, 0, 0, 4'b1111, 4'b1111, 4'b0000};
        tbl[2]  = '{1, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000};
        tbl[3]  = '{1, 0, 0, 0, 4'b1111, 4'b1111, 4'b0000};
        tbl[4]  = '{1, 1, 1, 5, 4'b0000, 4'b0000, 4'b0010};
        tbl[5]  = '{1, 0, 0, 0, 4'b1111, 4'b1111, 4'b0000};
        tbl[6]  = '{1, 0, 0, 0, 4'b0010, 4'b0000, 4'b0000};
        tbl[7]  = '{1, 0, 0, 0, 4'b1101, 4'b1101, 4'b0000};
        tbl[8]  = '{1, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000};
        tbl[9]  = '{1, 0, 0, 0, 4'b1101, 4'b1101, 4'b0000};
        tbl[10] = '{1, 0, 0, 0, 4'b0010, 4'b0010, 4'b0000};
        for (int k = 0; k < 11; k++) begin
            en = tbl[k].en; div_load = tbl[k].ld;
            div_sel = 2'(tbl[k].sel); div_val = 8'(tbl[k].val);
            step("tbl");
            check($sformatf("tbl%0d clk_out", k), clk_out, tbl[k].ec);
            check($sformatf("tbl%0d tick", k),    tick,    tbl[k].et);
            check($sformatf("tbl%0d pending", k), pending, tbl[k].ep);
        end
        div_load = 1'b0;

        // Channel 2 halted with D=0, then restarted with D=4.
        load(2, 0, "halt ld");
        for (int k = 0; k < 3; k++) step("halt settle");
        for (int k = 0; k < 10; k++) begin
            step("halt");
            check("halt clk2",  4'(clk_out[2]), 4'b0000);
            check("halt tick2", 4'(tick[2]),    4'b0000);
        end
        load(2, 4, "restart ld");
        check("restart clk2", 4'(clk_out[2]), 4'b0001);
        for (int k = 1; k <= 4; k++) begin
            step("restart");
            check($sformatf("restart tick2 +%0d", k), 4'(tick[2]), (k == 4) ? 4'b0001 : 4'b0000);
        end

        // Channel 0 D=6 with en dropped for 3 cycles at cnt=2: tick interval 9.
        load(0, 6, "en ld");
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            step("en wait");
            found = tick[0];
        end
        check("en wait tick0", 4'(found), 4'b0001);
        step("en run"); step("en run");
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step("en hold");
            check("en hold tick0", 4'(tick[0]), 4'b0000);
        end
        en = 1'b1;
        n = 0; found = 0;
        while (!found && n < 20) begin
            step("en resume");
            n++;
            found = tick[0];
        end
        check("en interval", 4'(n + 5), 4'(9));

        // Reset while channel 3 holds a pending D=7.
        pulse_reset();
        load(3, 7, "pend ld");
        check("pend3 set", pending, 4'b1000);
        pulse_reset();
        for (int k = 1; k <= 4; k++) begin
            step("post rst");
            check("post rst clk_out", clk_out, (k % 2 == 0) ? 4'b1111 : 4'b0000);
            check("post rst pending", pending, 4'b0000);
        end

`ifdef CLKDIV_SYNC_EN
        load(0, 3, "sync ld0");
        load(1, 6, "sync ld1");
        for (int k = 0; k < 15; k++) step("sync settle");
        sync = 1'b1;
        step("sync edge");
        sync = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step("sync run");
            check($sformatf("sync tick +%0d", k), {2'b00, tick[1:0]},
                  (k == 6) ? 4'b0011 : (k == 3) ? 4'b0001 : 4'b0000);
        end
`endif

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            en       = ($urandom % 8) != 0;
            div_load = ($urandom % 4) == 0;
            div_sel  = 2'($urandom % 4);
            div_val  = (($urandom % 10) < 8) ? 8'($urandom_range(0, 9)) : 8'($urandom % 256);
`ifdef CLKDIV_SYNC_EN
            sync     = ($urandom % 50) == 0;
`endif
            step("rand");
            if (($urandom % 400) == 0) pulse_reset();
        end
        div_load = 1'b0;
`ifdef CLKDIV_SYNC_EN
        sync = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
